// File: rtl/mole_round_sequencer.sv
// mole_round_sequencer: whack-a-mole round FSM picking the mole, timing the hit window and keeping score/misses; define ROUND_SEQ_SHRINK_EN to shrink the window on each hit
module mole_round_sequencer #(
  parameter int TICK_DIV  = 50000000,
  parameter int WIN_INIT  = 5,
  parameter int WIN_MIN   = 2,
  parameter int WIN_STEP  = 1,
  parameter int GAP_TICKS = 1,
  parameter int MAX_MISS  = 3
) (
  input  logic       systemClock,
  input  logic       reset,
  input  logic       startSwitch,
  input  logic       key_valid,
  input  logic [1:0] key_id,
  output logic [1:0] mole,
  output logic       mole_on,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [3:0] score,
  output logic [3:0] misses,
  output logic [3:0] window,
  output logic       game_over
);
  typedef enum logic [2:0] {IDLE, SHOW, JUDGE, GAP, OVER} state_t;
  localparam int PW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_TICKS + 1);
  if (TICK_DIV < 2 || WIN_INIT < 1 || WIN_INIT > 15 || WIN_MIN < 1 || WIN_MIN > WIN_INIT ||
      WIN_STEP < 0 || GAP_TICKS < 1 || MAX_MISS < 1 || MAX_MISS > 15) begin : g_bad_params
    $error("mole_round_sequencer: parameter out of range");
  end
  state_t        state, state_d;
  logic [7:0]    lfsr, lfsr_d;
  logic [PW-1:0] presc, presc_d;
  logic [3:0]    win_cnt, win_cnt_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic [1:0]    mole_d, pick;
  logic          mole_on_d, hit_d, miss_d, game_over_d, tick;
  logic [3:0]    score_d, misses_d, window_d, shrunk;
  assign tick = presc == PW'(TICK_DIV - 1);
  // never repeat the previous hole back to back
  assign pick = lfsr[1:0] + {1'b0, lfsr[1:0] == mole};
`ifdef ROUND_SEQ_SHRINK_EN
  assign shrunk = {1'b0, window} >= 5'(WIN_MIN + WIN_STEP) ? window - 4'(WIN_STEP) : 4'(WIN_MIN);
`else
  assign shrunk = window;
`endif
  always_comb begin
    state_d     = state;
    lfsr_d      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    presc_d     = tick ? '0 : presc + 1'b1;
    win_cnt_d   = win_cnt;
    gap_cnt_d   = gap_cnt;
    mole_d      = mole;
    mole_on_d   = mole_on;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    score_d     = score;
    misses_d    = misses;
    window_d    = window;
    game_over_d = game_over;
    case (state)
      IDLE: if (startSwitch) begin
        state_d   = SHOW;
        score_d   = '0;
        misses_d  = '0;
        window_d  = 4'(WIN_INIT);
        win_cnt_d = 4'(WIN_INIT);
        mole_d    = pick;
        mole_on_d = 1'b1;
        presc_d   = '0;
      end
      // a key in the expiry cycle still wins over the timeout
      SHOW: if (key_valid || (tick && win_cnt == 4'd1)) begin
        state_d   = JUDGE;
        mole_on_d = 1'b0;
        if (key_valid && key_id == mole) begin
          hit_d    = 1'b1;
          score_d  = &score ? score : score + 4'd1;
          window_d = shrunk;
        end else begin
          miss_d   = 1'b1;
          misses_d = misses + 4'd1;
        end
      end else if (tick) begin
        win_cnt_d = win_cnt - 4'd1;
      end
      JUDGE: begin
        state_d     = misses == 4'(MAX_MISS) ? OVER : GAP;
        game_over_d = misses == 4'(MAX_MISS);
        presc_d     = '0;
        gap_cnt_d   = GW'(GAP_TICKS);
      end
      GAP: if (tick) begin
        if (gap_cnt == GW'(1)) begin
          state_d   = SHOW;
          win_cnt_d = window;
          mole_d    = pick;
          mole_on_d = 1'b1;
          presc_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt - 1'b1;
        end
      end
      OVER: if (!startSwitch) begin
        state_d     = IDLE;
        game_over_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge systemClock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lfsr       <= 8'hA5;
      presc      <= '0;
      win_cnt    <= '0;
      gap_cnt    <= '0;
      mole       <= '0;
      mole_on    <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= '0;
      misses     <= '0;
      window     <= 4'(WIN_INIT);
      game_over  <= 1'b0;
    end else begin
      state      <= state_d;
      lfsr       <= lfsr_d;
      presc      <= presc_d;
      win_cnt    <= win_cnt_d;
      gap_cnt    <= gap_cnt_d;
      mole       <= mole_d;
      mole_on    <= mole_on_d;
      hit_pulse  <= hit_d;
      miss_pulse <= miss_d;
      score      <= score_d;
      misses     <= misses_d;
      window     <= window_d;
      game_over  <= game_over_d;
    end
  end
endmodule
